bpu_param: RTL and testbench

Parametrised next-generation branch prediction unit combining a per-slot 2-bit BHT and a per-slot BTB in one set-indexed, single-ported table.
- Serves one fetch-block lookup per cycle, with a registered 1-cycle response.
- Buffers resolved-branch updates in an internal queue and arbitrates them against lookups.
- Self-initialises the whole table after reset or after a flush request.
- Sits between the fetch PC generator and the backend branch-resolution logic.

---
 rtl/bpu_param.sv | 192 +++++++++++++++++++
 tb/tb_bpu_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_param.sv
// Set-indexed branch predictor: per-slot 2-bit counters and targets in one single-ported table,
// with a resolved-update queue and a self-initialising sweep. Optional BPU_PERF_CNT_EN adds perf counters.
module bpu_param #(
  parameter int SETS       = 512,
  parameter int INDEX_LSB  = 4,
  parameter int SLOTS      = 4,
  parameter int TARGET_W   = 32,
  parameter int UPDQ_DEPTH = 4,
  localparam int SLOT_W    = $clog2(SLOTS)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  output logic                      init_done_o,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [63:0]               req_pc_i,
  output logic                      resp_valid_o,
  output logic [SLOTS-1:0]          resp_hit_mask_o,
  output logic [SLOTS-1:0]          resp_taken_mask_o,
  output logic [SLOTS*TARGET_W-1:0] resp_targets_o,
  input  logic                      upd_valid_i,
  output logic                      upd_ready_o,
  input  logic [63:0]               upd_pc_i,
  input  logic [SLOT_W-1:0]         upd_slot_i,
  input  logic                      upd_taken_i,
  input  logic                      upd_alloc_i,
  input  logic [TARGET_W-1:0]       upd_target_i,
  input  logic                      flush_inval_i,
  output logic [31:0]               perf_lookup_cnt_o,
  output logic [31:0]               perf_miss_cnt_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int QA_W  = $clog2(UPDQ_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [SLOTS-1:0]                tbl_vld [SETS];
  logic [SLOTS-1:0][1:0]           tbl_ctr [SETS];
  logic [SLOTS-1:0][TARGET_W-1:0]  tbl_tgt [SETS];

  logic [IDX_W-1:0]    q_idx   [UPDQ_DEPTH];
  logic [SLOT_W-1:0]   q_slot  [UPDQ_DEPTH];
  logic                q_taken [UPDQ_DEPTH];
  logic                q_alloc [UPDQ_DEPTH];
  logic [TARGET_W-1:0] q_tgt   [UPDQ_DEPTH];
  logic [QA_W-1:0]     wr_q, rd_q;
  logic [QA_W:0]       cnt_q, cnt_d;

  logic                 run, kill, q_full, q_empty, lk_go, drain_go, enq, drain_we;
  logic [IDX_W-1:0]     lk_idx, h_idx;
  logic [SLOT_W-1:0]    h_slot;
  logic [1:0]           cur_ctr, new_ctr;
  logic [SLOTS-1:0]     lk_taken;
  logic                 resp_valid_q;
  logic [SLOTS-1:0]     resp_hit_q, resp_taken_q;
  logic [SLOTS*TARGET_W-1:0] resp_tgt_q;
  logic                 unused_pc;

  assign unused_pc = ^{req_pc_i, upd_pc_i};

  assign run      = (state_q == ST_RUN);
  assign kill     = run & flush_inval_i;
  assign q_full   = (cnt_q == (QA_W+1)'(UPDQ_DEPTH));
  assign q_empty  = (cnt_q == '0);
  assign req_ready_o = run & ~flush_inval_i & ~q_full;
  assign upd_ready_o = run & ~flush_inval_i & ~q_full;
  assign lk_go    = req_valid_i & req_ready_o;
  assign enq      = upd_valid_i & upd_ready_o;
  // a full queue steals the port from lookups; otherwise lookups win over drains
  assign drain_go = run & ~flush_inval_i & (q_full | (~req_valid_i & ~q_empty));
  assign lk_idx   = req_pc_i[INDEX_LSB +: IDX_W];

  assign h_idx    = q_idx[rd_q];
  assign h_slot   = q_slot[rd_q];
  assign cur_ctr  = tbl_ctr[h_idx][h_slot];
  assign drain_we = drain_go & (q_alloc[rd_q] | tbl_vld[h_idx][h_slot]);

  always_comb begin
    new_ctr = cur_ctr;
    if (q_alloc[rd_q])      new_ctr = q_taken[rd_q] ? 2'b10 : 2'b01;
    else if (q_taken[rd_q]) new_ctr = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
    else                    new_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
  end

  always_comb begin
    lk_taken = '0;
    for (int s = 0; s < SLOTS; s++) lk_taken[s] = tbl_vld[lk_idx][s] & tbl_ctr[lk_idx][s][1];
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + IDX_W'(1);
      if (sweep_q == IDX_W'(SETS-1)) state_d = ST_RUN;
    end else if (flush_inval_i) begin
      state_d = ST_INIT;
      sweep_d = '0;
    end
  end

  assign cnt_d = cnt_q + (QA_W+1)'(enq) - (QA_W+1)'(drain_go);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      if (kill) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (enq)      wr_q <= wr_q + QA_W'(1);
        if (drain_go) rd_q <= rd_q + QA_W'(1);
        cnt_q <= cnt_d;
      end
    end
  end

  // queue payload and table storage carry no reset; the sweep and pointers define validity
  always_ff @(posedge clock_i) begin
    if (enq) begin
      q_idx[wr_q]   <= upd_pc_i[INDEX_LSB +: IDX_W];
      q_slot[wr_q]  <= upd_slot_i;
      q_taken[wr_q] <= upd_taken_i;
      q_alloc[wr_q] <= upd_alloc_i;
      q_tgt[wr_q]   <= upd_target_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (state_q == ST_INIT) begin
      tbl_vld[sweep_q] <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        tbl_ctr[sweep_q][s] <= 2'b01;
        tbl_tgt[sweep_q][s] <= '0;
      end
    end else if (drain_we) begin
      tbl_vld[h_idx][h_slot] <= 1'b1;
      tbl_ctr[h_idx][h_slot] <= new_ctr;
      if (q_alloc[rd_q]) tbl_tgt[h_idx][h_slot] <= q_tgt[rd_q];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= '0;
      resp_taken_q <= '0;
      resp_tgt_q   <= '0;
    end else begin
      resp_valid_q <= lk_go;
      if (lk_go) begin
        resp_hit_q   <= tbl_vld[lk_idx];
        resp_taken_q <= lk_taken;
        resp_tgt_q   <= tbl_tgt[lk_idx];
      end
    end
  end

  assign init_done_o       = run;
  assign resp_valid_o      = resp_valid_q;
  assign resp_hit_mask_o   = resp_hit_q;
  assign resp_taken_mask_o = resp_taken_q;
  assign resp_targets_o    = resp_tgt_q;

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_lk_q, perf_miss_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_lk_q   <= '0;
      perf_miss_q <= '0;
    end else begin
      if (lk_go) perf_lk_q <= perf_lk_q + 32'd1;
      if (resp_valid_q && resp_hit_q == '0) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end
  assign perf_lookup_cnt_o = perf_lk_q;
  assign perf_miss_cnt_o   = perf_miss_q;
`else
  assign perf_lookup_cnt_o = '0;
  assign perf_miss_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_bpu_param.sv
// Bench for bpu_param: directed plan steps plus random traffic against a table/queue model.
module tb_bpu_param;
  localparam int SETS = 512, INDEX_LSB = 4, SLOTS = 4, TW = 32, QD = 4;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic init_done_o, req_valid_i = 0, req_ready_o, resp_valid_o;
  logic [63:0] req_pc_i = '0, upd_pc_i = '0;
  logic [SLOTS-1:0] resp_hit_mask_o, resp_taken_mask_o;
  logic [SLOTS*TW-1:0] resp_targets_o;
  logic upd_valid_i = 0, upd_ready_o, upd_taken_i = 0, upd_alloc_i = 0, flush_inval_i = 0;
  logic [1:0] upd_slot_i = '0;
  logic [TW-1:0] upd_target_i = '0;
  logic [31:0] perf_lookup_cnt_o, perf_miss_cnt_o;

  bpu_param dut (
    .clock_i(clk), .reset_i(rst), .init_done_o(init_done_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_pc_i(req_pc_i),
    .resp_valid_o(resp_valid_o), .resp_hit_mask_o(resp_hit_mask_o),
    .resp_taken_mask_o(resp_taken_mask_o), .resp_targets_o(resp_targets_o),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_pc_i(upd_pc_i),
    .upd_slot_i(upd_slot_i), .upd_taken_i(upd_taken_i), .upd_alloc_i(upd_alloc_i),
    .upd_target_i(upd_target_i), .flush_inval_i(flush_inval_i),
    .perf_lookup_cnt_o(perf_lookup_cnt_o), .perf_miss_cnt_o(perf_miss_cnt_o)
  );

  int vecs = 0, errs = 0;

  // reference: plain per-slot state plus a FIFO of pending updates
  bit          mv [SETS][SLOTS];
  int          mc [SETS][SLOTS];
  logic [TW-1:0] mt [SETS][SLOTS];
  typedef struct { int set; int slot; bit tk; bit al; logic [TW-1:0] tgt; } upd_t;
  upd_t mq[$];
  logic [31:0] e_lk = 0, e_miss = 0;
  bit pend = 0, e_rv = 0, a;
  logic [SLOTS-1:0] e_hit, e_tkn;
  logic [SLOTS*TW-1:0] e_tgt;
  logic [63:0] pcs [4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int set_of(input logic [63:0] pc);
    return int'((pc >> INDEX_LSB) % SETS);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++)
      for (int s = 0; s < SLOTS; s++) begin mv[i][s] = 0; mc[i][s] = 1; mt[i][s] = '0; end
  endtask

  task automatic drain();
    upd_t u = mq.pop_front();
    if (u.al) begin
      mv[u.set][u.slot] = 1; mt[u.set][u.slot] = u.tgt; mc[u.set][u.slot] = u.tk ? 2 : 1;
    end else if (mv[u.set][u.slot]) begin
      if (u.tk) mc[u.set][u.slot] = (mc[u.set][u.slot] >= 3) ? 3 : mc[u.set][u.slot] + 1;
      else      mc[u.set][u.slot] = (mc[u.set][u.slot] <= 0) ? 0 : mc[u.set][u.slot] - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    e_miss += 32'(pend);
    pend = e_rv && (e_hit == '0);
    chk("resp_valid", resp_valid_o, e_rv);
    if (e_rv) begin
      chk("hit_mask", resp_hit_mask_o, e_hit);
      chk("taken_mask", resp_taken_mask_o, e_tkn);
      chk("targets", resp_targets_o, e_tgt);
    end
`ifdef BPU_PERF_CNT_EN
    chk("perf_lookup", perf_lookup_cnt_o, e_lk);
    chk("perf_miss", perf_miss_cnt_o, e_miss);
`else
    chk("perf_lookup", perf_lookup_cnt_o, 0);
    chk("perf_miss", perf_miss_cnt_o, 0);
`endif
  endtask

  task automatic cycle(input bit rv, input logic [63:0] rpc, input bit uv, input logic [63:0] upc,
                       input int us, input bit tk, input bit al, input logic [TW-1:0] tg,
                       input bit fl, output bit acc);
    bit rdy; int st;
    req_valid_i = rv; req_pc_i = rpc; upd_valid_i = uv; upd_pc_i = upc; upd_slot_i = 2'(us);
    upd_taken_i = tk; upd_alloc_i = al; upd_target_i = tg; flush_inval_i = fl;
    rdy = !fl && (mq.size() < QD);
    #1;
    chk("req_ready", req_ready_o, rdy);
    chk("upd_ready", upd_ready_o, rdy);
    e_rv = 0;
    acc = uv && rdy;
    if (fl) mq.delete();
    else begin
      if (mq.size() == QD) drain();
      else if (rv) begin
        e_rv = 1; e_lk++; st = set_of(rpc);
        for (int s = 0; s < SLOTS; s++) begin
          e_hit[s] = mv[st][s];
          e_tkn[s] = mv[st][s] && (mc[st][s] >= 2);
          e_tgt[s*TW +: TW] = mt[st][s];
        end
      end else if (mq.size() > 0) drain();
      if (acc) mq.push_back('{set_of(upc), us, tk, al, tg});
    end
    tick();
    chk("init_done", init_done_o, !fl);
    req_valid_i = 0; upd_valid_i = 0; flush_inval_i = 0;
  endtask

  task automatic lookup(input logic [63:0] pc);
    bit x; cycle(1, pc, 0, 0, 0, 0, 0, 0, 0, x);
  endtask
  task automatic idle();
    bit x; cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, x);
  endtask
  task automatic update(input logic [63:0] pc, input int sl, input bit tk, input bit al,
                        input logic [TW-1:0] tg);
    bit x; cycle(0, 0, 1, pc, sl, tk, al, tg, 0, x);
  endtask

  // sweep lasts exactly SETS edges; ready stays low until the last one
  task automatic wait_init();
    model_clear();
    mq.delete();
    for (int i = 1; i <= SETS; i++) begin
      e_rv = 0;
      tick();
      chk("init_done_sweep", init_done_o, i == SETS);
      if (i < SETS) begin
        chk("req_ready_init", req_ready_o, 0);
        chk("upd_ready_init", upd_ready_o, 0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_init_done", init_done_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_upd_ready", upd_ready_o, 0);
    chk("rst_hit", resp_hit_mask_o, 0);
    chk("rst_targets", resp_targets_o, 0);
    chk("rst_perf_lk", perf_lookup_cnt_o, 0);
    chk("rst_perf_miss", perf_miss_cnt_o, 0);
    e_lk = 0; e_miss = 0; pend = 0; e_rv = 0;
    @(negedge clk);
    rst = 0;
    wait_init();
  endtask

  initial begin
    pcs[0] = 64'h1230; pcs[1] = 64'h2000; pcs[2] = 64'h2010; pcs[3] = 64'h1230 + 64'(SETS * 16);

    do_reset();

    // cold lookup misses
    lookup(64'h1230);
    chk("cold_hit", resp_hit_mask_o, 4'b0000);
    chk("cold_taken", resp_taken_mask_o, 4'b0000);

    // allocate slot 2 taken, then look it up
    update(64'h1230, 2, 1, 1, 32'hDEAD_BEE0);
    idle();
    lookup(64'h1230);
    chk("alloc_hit", resp_hit_mask_o, 4'b0100);
    chk("alloc_taken", resp_taken_mask_o, 4'b0100);
    chk("alloc_tgt", resp_targets_o[2*TW +: TW], 32'hDEAD_BEE0);

    // three not-taken updates saturate the counter at 0
    for (int k = 0; k < 3; k++) begin update(64'h1230, 2, 0, 0, 0); idle(); end
    lookup(64'h1230);
    chk("nt_hit", resp_hit_mask_o, 4'b0100);
    chk("nt_taken", resp_taken_mask_o, 4'b0000);

    // non-alloc update to an invalid slot must not write
    update(64'h1230, 1, 1, 0, 32'h1111_1110);
    idle();
    lookup(64'h1230);
    chk("inval_upd_hit", resp_hit_mask_o, 4'b0100);

    // continuous lookups while pushing 5 updates: full queue steals one cycle per drain
    begin
      int k = 0;
      while (k < 5) begin
        cycle(1, pcs[k % 4], 1, pcs[k % 4], k % SLOTS, 1, 1, 32'hA000_0000 + 32'(k), 0, a);
        if (a) k++;
      end
      for (int j = 0; j < 3; j++) lookup(pcs[j]);
      for (int j = 0; j < 5; j++) idle();
      for (int j = 0; j < 4; j++) lookup(pcs[j]);
      chk("q_empty_after_drain", mq.size(), 0);
    end

    // randomized traffic over a few aliasing sets
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 1), pcs[$urandom_range(0, 3)], $urandom_range(0, 1),
            pcs[$urandom_range(0, 3)], $urandom_range(0, SLOTS-1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom, 0, a);
    end
    for (int j = 0; j < 6; j++) idle();

    // flush with 2 queued updates: they are discarded and the table re-sweeps
    cycle(1, pcs[0], 1, 64'h3000, 0, 1, 1, 32'h5555_0000, 0, a);
    cycle(1, pcs[1], 1, 64'h3010, 1, 1, 1, 32'h6666_0000, 0, a);
    chk("two_queued", mq.size(), 2);
    cycle(1, pcs[0], 0, 0, 0, 0, 0, 0, 1, a);
    wait_init();
    for (int j = 0; j < 4; j++) idle();
    lookup(64'h3000);
    chk("flush_hit0", resp_hit_mask_o, 4'b0000);
    lookup(64'h3010);
    chk("flush_hit1", resp_hit_mask_o, 4'b0000);
    lookup(64'h1230);
    chk("flush_hit2", resp_hit_mask_o, 4'b0000);

    // reset mid-operation with a lookup in flight and updates queued
    cycle(1, pcs[2], 1, 64'h4000, 3, 1, 1, 32'h7777_0000, 0, a);
    cycle(1, pcs[3], 1, 64'h4010, 3, 1, 1, 32'h8888_0000, 0, a);
    do_reset();
    for (int j = 0; j < 4; j++) idle();
    lookup(64'h4000);
    chk("rst_mid_hit0", resp_hit_mask_o, 4'b0000);
    lookup(64'h4010);
    chk("rst_mid_hit1", resp_hit_mask_o, 4'b0000);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
